regfile_seq: RTL and testbench
==============================

Name: regfile_seq

Overview:
- Micro-sequencer that owns the 3-entry 8-bit register file: accepts encoded instructions over a valid/ready handshake and drives the file's read/write addresses, active-low write enable and write data.
- Performs MOV/LDI/ADD/SUB with a small internal adder.
- Sits between the instruction source (front panel or fetch unit) and the register file; it is the only writer of the register file.

Parameters:
- DW, 8, data width of register file and immediate.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction or immediate byte present.
- instr_ready  out  1  sequencer accepts a byte this cycle.
- instr  in  8  [7:6] opcode (00 MOV, 01 LDI, 10 ADD, 11 SUB), [5:4] dst, [3:2] src, [1:0] ignored.
- rf_ra  out  2  register file read address (src).
- rf_wa  out  2  register file write/second-read address (dst).
- rf_we_n  out  1  register file write enable, active low.
- rf_wdata  out  DW  register file write data.
- rf_s  in  DW  register file read port for rf_ra.
- rf_d  in  DW  register file read port for rf_wa.
- done  out  1  one-cycle pulse in the cycle the write is issued.
- err  out  1  one-cycle pulse: illegal register index, instruction dropped.
- flag_z  out  1  zero flag from last ADD/SUB.
- flag_c  out  1  carry (ADD) / borrow (SUB) from last ADD/SUB.

Behaviour:
- Reset, sampled at posedge rst=1: state IDLE; rf_ra=0, rf_wa=0, rf_wdata=0, done=0, err=0, flag_z=0, flag_c=0.
  - instr_ready=0 while rst=1.
  - rf_we_n=1 combinationally whenever rst=1.
  - Register file contents are not reset by this block.
- States: IDLE, IMM, READ, EXEC, WRITE.
- instr_ready=1 only in IDLE and IMM. A transfer occurs when instr_valid & instr_ready at posedge.
- IDLE + transfer:
  - Latch opcode, dst, src.
  - If dst==3, or src==3 for MOV/ADD/SUB, pulse err next cycle and stay IDLE.
  - LDI -> IMM. Otherwise -> READ.
- IMM + transfer: rf_wdata <= instr, -> WRITE. IMM waits indefinitely for valid; src field ignored.
- READ: rf_ra=src, rf_wa=dst held; -> EXEC.
- EXEC: sample rf_s, rf_d.
  - MOV: wdata=S.
  - ADD: {c,wdata}=D+S.
  - SUB: wdata=D-S, c=(S>D).
  - ADD/SUB update flag_z=(wdata==0) and flag_c; MOV leaves flags unchanged.
  - -> WRITE.
- WRITE: rf_wa=dst; rf_we_n=0 (decoded from state, gated by rst); done=1. The register file captures on the following negedge. -> IDLE.
- Latency from handshake:
  - MOV/ADD/SUB: WRITE in cycle 3. Next instruction can be accepted in cycle 4, so throughput is 1 instruction per 4 cycles.
  - LDI: WRITE one cycle after the immediate is accepted.
- rf_we_n is never 0 outside WRITE. Only one write occurs per instruction.
- Arithmetic is modulo 2^DW (wrap): 0xFF+0x01 = 0x00, z=1, c=1.
- Reset mid-operation: rst=1 in any state aborts the instruction, with no write. rst asserted during WRITE forces rf_we_n=1 in that cycle, so no negedge write occurs.
- dst==src is legal: ADD a,a doubles a.

Optional Feature:
- Macro REGFILE_SEQ_SAT_EN.
- Defined: ADD clamps to 0xFF on carry; SUB clamps to 0x00 on borrow. flag_c still reports the overflow/borrow, and flag_z is computed on the clamped result.
- Undefined: wrap-around arithmetic as above.

Decomposition:
- Package regfile_seq_pkg holds:
  - opcode enum (OP_MOV, OP_LDI, OP_ADD, OP_SUB);
  - state enum;
  - register index constants REG_A=0, REG_B=1, REG_C=2, REG_BAD=3.
- One combinational sub-module, regfile_seq_alu: inputs op, d, s; outputs result, carry, zero; contains the saturation ifdef.
- FSM, latches and handshake stay in regfile_seq.

Test Plan:
- LDI a: send 0x40 then 0x5A -> one WRITE cycle with rf_wa=0, rf_wdata=0x5A, rf_we_n=0, done=1; flags unchanged.
- With a=0x05, b=0x03, send ADD a,b (0x84) -> rf_ra=1, rf_wa=0 in READ; WRITE in cycle 3 with wdata=0x08, z=0, c=0.
- With a=0x03, b=0x05, send SUB a,b (0xC4):
  - without macro -> wdata=0xFE, c=1, z=0;
  - with REGFILE_SEQ_SAT_EN -> wdata=0x00, c=1, z=1.
- Send MOV with dst=3 (0x30) -> err pulses once, rf_we_n stays 1, instr_ready returns to 1 the next cycle.
- Hold instr_valid high with back-to-back MOV b,a (0x10) -> accepts spaced 4 cycles apart, exactly one rf_we_n=0 cycle per instruction.
- Assert rst in WRITE of ADD c,c (0xA8) -> rf_we_n=1 that cycle, done=0; after reset, state IDLE and all outputs at reset values.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the regfile_seq micro-sequencer.
// Optional build macro used by this slice: REGFILE_SEQ_SAT_EN (saturating ADD/SUB).
package regfile_seq_pkg;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_LDI = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IMM   = 3'd1,
    ST_READ  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  localparam logic [1:0] REG_A   = 2'd0;
  localparam logic [1:0] REG_B   = 2'd1;
  localparam logic [1:0] REG_C   = 2'd2;
  localparam logic [1:0] REG_BAD = 2'd3;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational adder/subtractor for regfile_seq: result = D op S, with carry/borrow and zero.
// With REGFILE_SEQ_SAT_EN defined, ADD clamps to all-ones on carry and SUB clamps to zero on borrow.
module regfile_seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int DW = 8
) (
  input  op_t            op,
  input  logic [DW-1:0]  d,
  input  logic [DW-1:0]  s,
  output logic [DW-1:0]  result,
  output logic           carry,
  output logic           zero
);

`ifdef REGFILE_SEQ_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Clamp only on overflow; carry out of ADD saturates high, borrow out of SUB saturates low.
  function automatic logic [DW-1:0] sat_result(input op_t f_op,
                                               input logic [DW-1:0] raw,
                                               input logic ovf);
    if (SAT_EN && ovf)
      return (f_op == OP_ADD) ? {DW{1'b1}} : {DW{1'b0}};
    return raw;
  endfunction

  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic [DW-1:0] raw;
  logic          ovf;

  always_comb begin
    sum  = {1'b0, d} + {1'b0, s};
    diff = {1'b0, d} - {1'b0, s};
    raw  = s;
    ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        raw = sum[DW-1:0];
        ovf = sum[DW];
      end
      OP_SUB: begin
        raw = diff[DW-1:0];
        ovf = diff[DW];
      end
      default: begin
        raw = s;
        ovf = 1'b0;
      end
    endcase
    result = sat_result(op, raw, ovf);
    carry  = ovf;
    zero   = (result == {DW{1'b0}});
  end

endmodule

// File: rtl/regfile_seq.sv
// Micro-sequencer owning a 3-entry register file: decodes MOV/LDI/ADD/SUB bytes and drives the file's ports.
// Build option: REGFILE_SEQ_SAT_EN selects saturating arithmetic inside regfile_seq_alu.
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [7:0]     instr,
  output logic [1:0]     rf_ra,
  output logic [1:0]     rf_wa,
  output logic           rf_we_n,
  output logic [DW-1:0]  rf_wdata,
  input  logic [DW-1:0]  rf_s,
  input  logic [DW-1:0]  rf_d,
  output logic           done,
  output logic           err,
  output logic           flag_z,
  output logic           flag_c
);

  state_t        state_q;
  state_t        state_d;
  op_t           op_q;
  op_t           dec_op;
  logic [1:0]    dec_dst;
  logic [1:0]    dec_src;
  logic          illegal;
  logic          xfer;
  logic [DW-1:0] alu_res;
  logic          alu_carry;
  logic          alu_zero;
  logic          unused_instr_bits;

  assign dec_op            = op_t'(instr[7:6]);
  assign dec_dst           = instr[5:4];
  assign dec_src           = instr[3:2];
  assign unused_instr_bits = ^instr[1:0];
  assign xfer              = instr_valid & instr_ready;

  // LDI has no source operand, so only its destination can be out of range.
  assign illegal = (dec_dst == REG_BAD) || ((dec_op != OP_LDI) && (dec_src == REG_BAD));

  regfile_seq_alu #(.DW(DW)) u_alu (
    .op     (op_q),
    .d      (rf_d),
    .s      (rf_s),
    .result (alu_res),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer && !illegal)
          state_d = (dec_op == OP_LDI) ? ST_IMM : ST_READ;
      end
      ST_IMM:   if (xfer) state_d = ST_WRITE;
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Write strobe is decoded from state and gated by rst so a reset in WRITE suppresses the negedge write.
  always_comb begin
    instr_ready = 1'b0;
    rf_we_n     = 1'b1;
    done        = 1'b0;
    if (!rst) begin
      instr_ready = (state_q == ST_IDLE) || (state_q == ST_IMM);
      rf_we_n     = (state_q != ST_WRITE);
      done        = (state_q == ST_WRITE);
    end
  end

  // rf_ra/rf_wa double as the latched src/dst fields for the whole instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_MOV;
      rf_ra    <= REG_A;
      rf_wa    <= REG_A;
      rf_wdata <= '0;
      err      <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            if (illegal) begin
              err <= 1'b1;
            end else begin
              op_q  <= dec_op;
              rf_ra <= dec_src;
              rf_wa <= dec_dst;
            end
          end
        end
        ST_IMM: begin
          if (xfer) rf_wdata <= DW'(instr);
        end
        ST_EXEC: begin
          rf_wdata <= alu_res;
          if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
            flag_z <= alu_zero;
            flag_c <= alu_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq.sv
// Directed self-checking bench for regfile_seq with a behavioural 3-entry register file on negedge.
module tb_regfile_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [1:0] rf_ra;
  logic [1:0] rf_wa;
  logic       rf_we_n;
  logic [7:0] rf_wdata;
  logic [7:0] rf_s;
  logic [7:0] rf_d;
  logic       done;
  logic       err;
  logic       flag_z;
  logic       flag_c;

  logic [7:0] rf [0:3];

  int total = 0;
  int bad   = 0;

  regfile_seq #(.DW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_ra       (rf_ra),
    .rf_wa       (rf_wa),
    .rf_we_n     (rf_we_n),
    .rf_wdata    (rf_wdata),
    .rf_s        (rf_s),
    .rf_d        (rf_d),
    .done        (done),
    .err         (err),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  always #5 clk = ~clk;

  assign rf_s = rf[rf_ra];
  assign rf_d = rf[rf_wa];

  always @(negedge clk) begin
    if (!rf_we_n) rf[rf_wa] <= rf_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    instr_valid = 1'b1;
    instr       = b;
    tick();
    instr_valid = 1'b0;
    instr       = 8'h00;
  endtask

  task automatic ldi(input logic [1:0] dst, input logic [7:0] val);
    send({2'b01, dst, 4'b0000});
    send(val);
    tick();
  endtask

  // Expected results that depend on the saturation build option.
`ifdef REGFILE_SEQ_SAT_EN
  localparam logic [7:0] SUB_RES = 8'h00;
  localparam logic       SUB_Z   = 1'b1;
  localparam logic [7:0] WRAP_RES = 8'hFF;
  localparam logic       WRAP_Z   = 1'b0;
`else
  localparam logic [7:0] SUB_RES = 8'hFE;
  localparam logic       SUB_Z   = 1'b0;
  localparam logic [7:0] WRAP_RES = 8'h00;
  localparam logic       WRAP_Z   = 1'b1;
`endif

  initial begin
    int acc;
    int wr;
    int dn;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 8'h00;
    tick();
    tick();

    chk("rst_ready",  {31'b0, instr_ready}, 32'd0);
    chk("rst_we_n",   {31'b0, rf_we_n},     32'd1);
    chk("rst_done",   {31'b0, done},        32'd0);
    chk("rst_err",    {31'b0, err},         32'd0);
    chk("rst_flags",  {30'b0, flag_z, flag_c}, 32'd0);
    chk("rst_addr",   {28'b0, rf_ra, rf_wa}, 32'd0);
    chk("rst_wdata",  {24'b0, rf_wdata},    32'd0);

    rst = 1'b0;
    tick();
    chk("idle_ready", {31'b0, instr_ready}, 32'd1);

    // LDI a, 0x5A
    send(8'h40);
    chk("imm_ready",  {31'b0, instr_ready}, 32'd1);
    chk("imm_we_n",   {31'b0, rf_we_n},     32'd1);
    send(8'h5A);
    chk("ldi_we_n",   {31'b0, rf_we_n},     32'd0);
    chk("ldi_done",   {31'b0, done},        32'd1);
    chk("ldi_wa",     {30'b0, rf_wa},       32'd0);
    chk("ldi_wdata",  {24'b0, rf_wdata},    32'h5A);
    chk("ldi_flags",  {30'b0, flag_z, flag_c}, 32'd0);
    tick();
    chk("ldi_rf_a",   {24'b0, rf[0]},       32'h5A);
    chk("ldi_after_we_n", {31'b0, rf_we_n}, 32'd1);
    chk("ldi_after_done", {31'b0, done},    32'd0);

    // ADD a,b with a=5, b=3
    ldi(2'd0, 8'h05);
    ldi(2'd1, 8'h03);
    send(8'h84);
    chk("add_read_ra",    {30'b0, rf_ra},       32'd1);
    chk("add_read_wa",    {30'b0, rf_wa},       32'd0);
    chk("add_read_ready", {31'b0, instr_ready}, 32'd0);
    chk("add_read_we_n",  {31'b0, rf_we_n},     32'd1);
    tick();
    chk("add_exec_we_n",  {31'b0, rf_we_n},     32'd1);
    tick();
    chk("add_wr_we_n",    {31'b0, rf_we_n},     32'd0);
    chk("add_wr_done",    {31'b0, done},        32'd1);
    chk("add_wr_wdata",   {24'b0, rf_wdata},    32'h08);
    chk("add_wr_flags",   {30'b0, flag_z, flag_c}, 32'd0);
    tick();
    chk("add_rf_a",       {24'b0, rf[0]},       32'h08);

    // SUB a,b with a=3, b=5 (borrow)
    ldi(2'd0, 8'h03);
    ldi(2'd1, 8'h05);
    send(8'hC4);
    tick();
    tick();
    chk("sub_wr_we_n",    {31'b0, rf_we_n},     32'd0);
    chk("sub_wr_wdata",   {24'b0, rf_wdata},    {24'b0, SUB_RES});
    chk("sub_flag_c",     {31'b0, flag_c},      32'd1);
    chk("sub_flag_z",     {31'b0, flag_z},      {31'b0, SUB_Z});
    tick();

    // ADD a,b with 0xFF + 0x01 (carry out)
    ldi(2'd0, 8'hFF);
    ldi(2'd1, 8'h01);
    send(8'h84);
    tick();
    tick();
    chk("wrap_wdata",     {24'b0, rf_wdata},    {24'b0, WRAP_RES});
    chk("wrap_flag_c",    {31'b0, flag_c},      32'd1);
    chk("wrap_flag_z",    {31'b0, flag_z},      {31'b0, WRAP_Z});
    tick();
    chk("wrap_rf_a",      {24'b0, rf[0]},       {24'b0, WRAP_RES});

    // Illegal dst and illegal src
    send(8'h30);
    chk("err_dst_pulse",  {31'b0, err},         32'd1);
    chk("err_dst_we_n",   {31'b0, rf_we_n},     32'd1);
    chk("err_dst_ready",  {31'b0, instr_ready}, 32'd1);
    tick();
    chk("err_dst_clear",  {31'b0, err},         32'd0);
    send(8'hCC);
    chk("err_src_pulse",  {31'b0, err},         32'd1);
    chk("err_src_ready",  {31'b0, instr_ready}, 32'd1);
    tick();
    chk("err_src_clear",  {31'b0, err},         32'd0);
    chk("err_flags_kept", {30'b0, flag_z, flag_c}, {30'b0, WRAP_Z, 1'b1});

    // Back-to-back MOV b,a with valid held high
    ldi(2'd0, 8'h77);
    acc = 0;
    wr  = 0;
    dn  = 0;
    instr_valid = 1'b1;
    instr       = 8'h10;
    for (int i = 0; i < 12; i++) begin
      if (instr_ready) acc++;
      if (!rf_we_n) wr++;
      if (done) dn++;
      tick();
    end
    instr_valid = 1'b0;
    instr       = 8'h00;
    chk("b2b_accepts",    acc, 32'd3);
    chk("b2b_writes",     wr,  32'd3);
    chk("b2b_dones",      dn,  32'd3);
    tick();
    chk("b2b_rf_b",       {24'b0, rf[1]},       32'h77);
    chk("mov_flags_kept", {30'b0, flag_z, flag_c}, {30'b0, WRAP_Z, 1'b1});

    // Reset asserted during WRITE of ADD c,c
    ldi(2'd2, 8'h11);
    send(8'hA8);
    tick();
    tick();
    chk("rstw_pre_we_n",  {31'b0, rf_we_n},     32'd0);
    rst = 1'b1;
    #1;
    chk("rstw_we_n",      {31'b0, rf_we_n},     32'd1);
    chk("rstw_done",      {31'b0, done},        32'd0);
    tick();
    chk("rstw_rf_c",      {24'b0, rf[2]},       32'h11);
    chk("rstw_ready",     {31'b0, instr_ready}, 32'd0);
    chk("rstw_addr",      {28'b0, rf_ra, rf_wa}, 32'd0);
    chk("rstw_wdata",     {24'b0, rf_wdata},    32'd0);
    chk("rstw_flags",     {30'b0, flag_z, flag_c}, 32'd0);
    chk("rstw_err",       {31'b0, err},         32'd0);
    rst = 1'b0;
    tick();
    chk("rstw_idle_ready", {31'b0, instr_ready}, 32'd1);
    chk("rstw_idle_we_n",  {31'b0, rf_we_n},     32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
